// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if : hazard-request inputs and stall/flush outputs
// Rev 1.0
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic             dcache_miss;
  logic             dcache_ready;
  logic             icache_busy;
  logic             ex_branch_taken;
  logic             ex_is_load;
  logic [REG_W-1:0] ex_rd;
  logic [REG_W-1:0] id_rj;
  logic [REG_W-1:0] id_rk;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             mem_wb_flush;
  logic             redirect_pending;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] bubble_count;

  modport master (
    output dcache_miss, dcache_ready, icache_busy, ex_branch_taken,
           ex_is_load, ex_rd, id_rj, id_rk,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_flush, redirect_pending, stall_cycles,
           bubble_count
  );

  modport slave (
    input  dcache_miss, dcache_ready, icache_busy, ex_branch_taken,
           ex_is_load, ex_rd, id_rj, id_rk,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_flush, redirect_pending, stall_cycles,
           bubble_count
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl : stall/flush sequencer with saturating perf counters
// Rev 1.0
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  wire logic               clk,
  input  wire logic               rst,
  pipeline_hazard_ctrl_if.slave   bus
);
  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_DWAIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_pend;
  logic             w_pend_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic w_dstall;
  logic w_load_use;
  logic w_lu_fire;
  logic w_pc_stall;
  logic w_if_id_stall;
  logic w_if_id_flush;
  logic w_id_ex_stall;
  logic w_id_ex_flush;
  logic w_ex_mem_stall;
  logic w_mem_wb_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_pend       <= 1'b0;
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      if (w_pc_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_lu_fire && (r_bubble_cnt != {CNT_W{1'b1}}))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  // A fresh miss alongside a refill completion keeps us waiting.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (bus.dcache_miss) w_state_nxt = S_DWAIT;
      S_DWAIT: if (bus.dcache_ready && !bus.dcache_miss) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign w_dstall   = bus.dcache_miss | ((r_state == S_DWAIT) & ~bus.dcache_ready);
  assign w_load_use = bus.ex_is_load & (bus.ex_rd != '0) &
                      ((bus.ex_rd == bus.id_rj) | (bus.ex_rd == bus.id_rk));

  always_comb begin
    w_pc_stall     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_stall  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_stall = 1'b0;
    w_mem_wb_flush = 1'b0;
    w_lu_fire      = 1'b0;
    w_pend_nxt     = r_pend;
    if (w_dstall) begin
      w_pc_stall     = 1'b1;
      w_if_id_stall  = 1'b1;
      w_id_ex_stall  = 1'b1;
      w_ex_mem_stall = 1'b1;
      w_mem_wb_flush = 1'b1;
    end else if (bus.ex_branch_taken) begin
      // An in-flight fetch at redirect time is wrong-path; remember to drop it.
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
      w_pend_nxt    = bus.icache_busy;
    end else if (bus.icache_busy) begin
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_id_ex_flush = 1'b1;
      w_lu_fire     = w_load_use;
    end else if (r_pend) begin
      w_if_id_flush = 1'b1;
      w_pend_nxt    = 1'b0;
    end else if (w_load_use) begin
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_id_ex_flush = 1'b1;
      w_lu_fire     = 1'b1;
    end
  end

  assign bus.pc_stall         = w_pc_stall;
  assign bus.if_id_stall      = w_if_id_stall;
  assign bus.if_id_flush      = w_if_id_flush;
  assign bus.id_ex_stall      = w_id_ex_stall;
  assign bus.id_ex_flush      = w_id_ex_flush;
  assign bus.ex_mem_stall     = w_ex_mem_stall;
  assign bus.mem_wb_flush     = w_mem_wb_flush;
  assign bus.redirect_pending = r_pend;
  assign bus.stall_cycles     = r_stall_cnt;
  assign bus.bubble_count     = r_bubble_cnt;
endmodule
`default_nettype wire
